// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the physical-memory arbiter: state encoding, latched request
// and the request-capture helper.
package pmem_arbiter_pkg;

  localparam int unsigned SLine = 256;
  localparam int unsigned SAddr = 32;

  typedef logic [1:0] pmem_arb_state_t;

  localparam pmem_arb_state_t ArbIdle   = 2'd0;
  localparam pmem_arb_state_t ArbGrantI = 2'd1;
  localparam pmem_arb_state_t ArbGrantD = 2'd2;
  localparam pmem_arb_state_t ArbDone   = 2'd3;

  typedef struct packed {
    logic             read;
    logic             write;
    logic [SAddr-1:0] addr;
    logic [SLine-1:0] wdata;
  } pmem_req_t;

  // A requester raising both strobes is treated as a writeback; the read is discarded.
  function automatic pmem_req_t make_req(input logic             read,
                                         input logic             write,
                                         input logic [SAddr-1:0] addr,
                                         input logic [SLine-1:0] wdata);
    pmem_req_t r;
    r.read  = read & ~write;
    r.write = write;
    r.addr  = addr;
    r.wdata = wdata;
    return r;
  endfunction

endpackage

// File: rtl/pmem_arbiter_if.sv
// Cacheline memory port: the requester (master) drives strobes, address and write data;
// the memory side (slave) returns line data and a one-cycle completion.
interface pmem_arbiter_if;
  import pmem_arbiter_pkg::*;

  logic             read;
  logic             write;
  logic [SAddr-1:0] address;
  logic [SLine-1:0] wdata;
  logic [SLine-1:0] rdata;
  logic             resp;

  modport master (
    output read, write, address, wdata,
    input  rdata, resp
  );

  modport slave (
    input  read, write, address, wdata,
    output rdata, resp
  );

endinterface

// File: rtl/pmem_arb_picker.sv
// Combinational round-robin pick between the I-cache and D-cache requests.
module pmem_arb_picker (
  input  logic req_i,
  input  logic req_d,
  input  logic last_grant_d,
  output logic grant_i,
  output logic grant_d
);

  // On a tie the side that did not win last time is chosen.
  assign grant_i = req_i & (~req_d | last_grant_d);
  assign grant_d = req_d & (~req_i | ~last_grant_d);

endmodule

// File: rtl/pmem_arbiter.sv
// Shares the single cacheline-adaptor port between the I-cache and D-cache miss paths,
// one transaction at a time, with a dead cycle after each completion.
module pmem_arbiter
  import pmem_arbiter_pkg::*;
(
  input logic            clk,
  input logic            rst,
  pmem_arbiter_if.slave  i_bus,
  pmem_arbiter_if.slave  d_bus,
  pmem_arbiter_if.master mem_bus
);

  pmem_arb_state_t state_q, state_d;
  logic            last_d_q, last_d_d;
  pmem_req_t       hold_q, hold_d;

  logic req_i, req_d;
  logic grant_i, grant_d;
  logic i_resp, d_resp;
  logic granted;

  assign req_i = i_bus.read | i_bus.write;
  assign req_d = d_bus.read | d_bus.write;

  pmem_arb_picker u_picker (
    .req_i        (req_i),
    .req_d        (req_d),
    .last_grant_d (last_d_q),
    .grant_i      (grant_i),
    .grant_d      (grant_d)
  );

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    hold_d   = hold_q;
    i_resp   = 1'b0;
    d_resp   = 1'b0;
    case (state_q)
      ArbIdle: begin
        if (grant_i) begin
          hold_d  = make_req(i_bus.read, i_bus.write, i_bus.address, i_bus.wdata);
          state_d = ArbGrantI;
        end else if (grant_d) begin
          hold_d  = make_req(d_bus.read, d_bus.write, d_bus.address, d_bus.wdata);
          state_d = ArbGrantD;
        end
      end
      ArbGrantI: begin
        if (mem_bus.resp) begin
          i_resp   = 1'b1;
          last_d_d = 1'b0;
          state_d  = ArbDone;
        end
      end
      ArbGrantD: begin
        if (mem_bus.resp) begin
          d_resp   = 1'b1;
          last_d_d = 1'b1;
          state_d  = ArbDone;
        end
      end
      ArbDone:  state_d = ArbIdle;
      default:  state_d = ArbIdle;
    endcase
  end

  // last_grant resets to D so the I-cache wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ArbIdle;
      last_d_q <= 1'b1;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      hold_q   <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state_q == ArbIdle) begin
      assert (!(grant_i && i_bus.read && i_bus.write))
        else $warning("pmem_arbiter: I-cache raised read and write together");
      assert (!(grant_d && d_bus.read && d_bus.write))
        else $warning("pmem_arbiter: D-cache raised read and write together");
    end
  end

  assign granted = (state_q == ArbGrantI) || (state_q == ArbGrantD);

  assign mem_bus.read    = granted & hold_q.read;
  assign mem_bus.write   = granted & hold_q.write;
  assign mem_bus.address = hold_q.addr;
  assign mem_bus.wdata   = hold_q.wdata;

  assign i_bus.rdata = mem_bus.rdata;
  assign d_bus.rdata = mem_bus.rdata;
  assign i_bus.resp  = i_resp;
  assign d_bus.resp  = d_resp;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: single-side reads/writebacks, round-robin ties,
// mid-grant request changes, reset mid-transaction and stray completions.
module tb_pmem_arbiter;
  import pmem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pmem_arbiter_if i_if ();
  pmem_arbiter_if d_if ();
  pmem_arbiter_if m_if ();

  pmem_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .i_bus   (i_if),
    .d_bus   (d_if),
    .mem_bus (m_if)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called in an IDLE cycle with the winner's request already driven. Models an adaptor
  // answering on the (n+1)-th cycle of the downstream strobe, then checks the dead cycle.
  task automatic serve(input bit side_d, input int n, input bit exp_wr,
                       input logic [31:0] exp_addr, input logic [255:0] exp_wdata,
                       input bit chg_addr);
    logic [255:0] rd;
    rd = {8{32'hC0DE_0000 ^ exp_addr}};
    for (int k = 1; k <= n + 1; k++) begin
      @(negedge clk);
      if (chg_addr && k == 2) d_if.address = 32'h0000_0300;
      if (k == n + 1) begin
        m_if.resp  = 1'b1;
        m_if.rdata = rd;
      end
      #1;
      chk("pmem_read", m_if.read, !exp_wr);
      chk("pmem_write", m_if.write, exp_wr);
      chk("pmem_address", m_if.address, exp_addr);
      chk("pmem_wdata", m_if.wdata, exp_wdata);
      chk("i_resp", i_if.resp, (k == n + 1) && !side_d);
      chk("d_resp", d_if.resp, (k == n + 1) && side_d);
      if (k == n + 1) begin
        chk("i_rdata", i_if.rdata, rd);
        chk("d_rdata", d_if.rdata, rd);
      end
    end
    @(negedge clk);
    m_if.resp = 1'b0;
    if (side_d) begin
      d_if.read  = 1'b0;
      d_if.write = 1'b0;
    end else begin
      i_if.read  = 1'b0;
      i_if.write = 1'b0;
    end
    #1;
    chk("done_read", m_if.read, 1'b0);
    chk("done_write", m_if.write, 1'b0);
    chk("done_i_resp", i_if.resp, 1'b0);
    chk("done_d_resp", d_if.resp, 1'b0);
  endtask

  initial begin
    i_if.read = 1'b0; i_if.write = 1'b0; i_if.address = '0; i_if.wdata = '0;
    d_if.read = 1'b0; d_if.write = 1'b0; d_if.address = '0; d_if.wdata = '0;
    m_if.resp = 1'b0; m_if.rdata = '0;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_read", m_if.read, 1'b0);
    chk("rst_write", m_if.write, 1'b0);
    chk("rst_address", m_if.address, 32'h0);
    chk("rst_wdata", m_if.wdata, 256'h0);
    chk("rst_i_resp", i_if.resp, 1'b0);
    chk("rst_d_resp", d_if.resp, 1'b0);
    rst = 1'b0;

    // I-cache read only, adaptor latency 4
    @(negedge clk);
    i_if.read = 1'b1; i_if.address = 32'h0000_0060; i_if.wdata = {8{32'h1111_1111}};
    #1;
    chk("t1_req_cycle_read", m_if.read, 1'b0);
    serve(1'b0, 4, 1'b0, 32'h0000_0060, {8{32'h1111_1111}}, 1'b0);

    // D-cache writeback
    @(negedge clk);
    d_if.write = 1'b1; d_if.address = 32'h8000_00A0; d_if.wdata = {8{32'hDEAD_BEEF}};
    serve(1'b1, 2, 1'b1, 32'h8000_00A0, {8{32'hDEAD_BEEF}}, 1'b0);

    // Tie after reset: I first, then a repeated tie goes to D (with a mid-grant address change)
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    i_if.read = 1'b1; i_if.address = 32'h0000_0100; i_if.wdata = {8{32'hAAAA_0001}};
    d_if.read = 1'b1; d_if.address = 32'h0000_0200; d_if.wdata = {8{32'hBBBB_0002}};
    serve(1'b0, 1, 1'b0, 32'h0000_0100, {8{32'hAAAA_0001}}, 1'b0);
    @(negedge clk);
    i_if.read = 1'b1;
    serve(1'b1, 3, 1'b0, 32'h0000_0200, {8{32'hBBBB_0002}}, 1'b1);
    @(negedge clk);
    serve(1'b0, 1, 1'b0, 32'h0000_0100, {8{32'hAAAA_0001}}, 1'b0);

    // Reset during a D grant; the late completion must not reach either cache
    @(negedge clk);
    d_if.read = 1'b1; d_if.address = 32'h0000_0400;
    @(negedge clk);
    #1;
    chk("t5_granted_read", m_if.read, 1'b1);
    chk("t5_granted_addr", m_if.address, 32'h0000_0400);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("t5_reset_read", m_if.read, 1'b0);
    chk("t5_reset_addr", m_if.address, 32'h0);
    rst = 1'b0;
    d_if.read = 1'b0;
    m_if.resp = 1'b1;
    #1;
    chk("t5_late_i_resp", i_if.resp, 1'b0);
    chk("t5_late_d_resp", d_if.resp, 1'b0);

    // Stray completion in IDLE
    @(negedge clk);
    #1;
    chk("t6_stray_read", m_if.read, 1'b0);
    chk("t6_stray_i_resp", i_if.resp, 1'b0);
    chk("t6_stray_d_resp", d_if.resp, 1'b0);
    m_if.resp = 1'b0;

    // D raises read and write together: issued as a write
    @(negedge clk);
    d_if.read = 1'b1; d_if.write = 1'b1;
    d_if.address = 32'h0000_0500; d_if.wdata = {8{32'h5555_AAAA}};
    serve(1'b1, 2, 1'b1, 32'h0000_0500, {8{32'h5555_AAAA}}, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
